// File: rtl/regfile_mp_dump_pkg.sv
// regfile_pkg: shared types for the multi-port register file with dump engine.
//   - default widths (data, address, read-port count)
//   - dump FSM state encoding
//   - rd_slice(): bit offset of a port's field inside a packed bus
// Optional feature macro used by the top: REGFILE_WR_BYPASS_EN.
package regfile_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_ADDR_DEF = 5;
  localparam int N_READ_DEF  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } dump_state_e;

  // Offset of field k in a bus of fields that are nb bits wide each.
  function automatic int rd_slice(input int k, input int nb);
    return k * nb;
  endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// regfile_dump_fsm: streams every register out over a valid/ready port.
// Holds the beat pointer, the FSM state and the registered beat data.
// The next register is fetched through o_rf_addr/i_rf_data and captured on
// the handshake edge, so a held beat never changes while stalled.
// Ports:
//   clk, i_reset             clock, async active-high reset
//   i_dump_start             one-cycle start request (ignored while busy)
//   i_dump_ready             consumer accepts current beat
//   o_rf_addr / i_rf_data    register-array read port (address of next beat)
//   o_dump_valid/addr/data/last/busy   beat outputs
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic [NB_ADDR-1:0] o_rf_addr,
  input  logic [NB_DATA-1:0] i_rf_data,
  output logic               o_dump_valid,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_last,
  output logic               o_dump_busy
);

  localparam logic [NB_ADDR-1:0] LAST_IDX = '1;

  dump_state_e        state, state_nxt;
  logic [NB_ADDR-1:0] ptr, ptr_nxt;
  logic [NB_DATA-1:0] data, data_nxt;
  logic               hs;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
      data  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      data  <= data_nxt;
    end
  end

  // Next beat's register; its pre-edge value is what gets captured.
  assign o_rf_addr = ptr + 1'b1;
  assign hs        = (state == ST_SEND) && i_dump_ready;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    data_nxt  = data;
    case (state)
      ST_IDLE: begin
        if (i_dump_start) begin
          state_nxt = ST_SEND;
          ptr_nxt   = '0;
          data_nxt  = '0;  // register 0 is hard-wired zero
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (ptr == LAST_IDX) begin
            state_nxt = ST_IDLE;
            ptr_nxt   = '0;
            data_nxt  = '0;
          end else begin
            ptr_nxt  = ptr + 1'b1;
            data_nxt = i_rf_data;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_dump_valid = (state == ST_SEND);
  assign o_dump_busy  = (state == ST_SEND);
  assign o_dump_addr  = ptr;
  assign o_dump_data  = data;
  assign o_dump_last  = (state == ST_SEND) && (ptr == LAST_IDX);

endmodule

// File: rtl/regfile_mp_dump.sv
// regfile_mp_dump: register file with N_READ combinational read ports, one
// posedge write port, hard-wired zero register and a debug dump engine.
// Macro REGFILE_WR_BYPASS_EN: when defined, a read port whose address matches
// an active same-cycle write (address != 0) returns the write data directly.
// The dump path always sees array contents only.
// Ports:
//   clk, i_reset                   clock, async active-high reset
//   i_we, i_wr_addr, i_wr_data     write port (address 0 dropped)
//   i_rd_addr, o_rd_data           packed read ports, port k at k*width
//   i_dump_start, i_dump_ready     dump control / backpressure
//   o_dump_valid/addr/data/last/busy   dump beat stream
module regfile_mp_dump
  import regfile_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF,
  parameter int N_READ  = N_READ_DEF
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic                      i_we,
  input  logic [NB_ADDR-1:0]        i_wr_addr,
  input  logic [NB_DATA-1:0]        i_wr_data,
  input  logic [N_READ*NB_ADDR-1:0] i_rd_addr,
  output logic [N_READ*NB_DATA-1:0] o_rd_data,
  input  logic                      i_dump_start,
  output logic                      o_dump_valid,
  input  logic                      i_dump_ready,
  output logic [NB_ADDR-1:0]        o_dump_addr,
  output logic [NB_DATA-1:0]        o_dump_data,
  output logic                      o_dump_last,
  output logic                      o_dump_busy
);

  localparam int DEPTH = 2 ** NB_ADDR;

  logic [DEPTH-1:0][NB_DATA-1:0] regs;
  logic [NB_ADDR-1:0]            dump_rf_addr;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset)
      regs <= '0;
    else if (i_we && (i_wr_addr != '0))
      regs[i_wr_addr] <= i_wr_data;
  end

  for (genvar k = 0; k < N_READ; k++) begin : g_rd
    logic [NB_ADDR-1:0] ra;
    assign ra = i_rd_addr[rd_slice(k, NB_ADDR) +: NB_ADDR];
`ifdef REGFILE_WR_BYPASS_EN
    assign o_rd_data[rd_slice(k, NB_DATA) +: NB_DATA] =
      (i_we && (i_wr_addr == ra) && (ra != '0)) ? i_wr_data : regs[ra];
`else
    assign o_rd_data[rd_slice(k, NB_DATA) +: NB_DATA] = regs[ra];
`endif
  end

  regfile_dump_fsm #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_dump (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_dump_start (i_dump_start),
    .i_dump_ready (i_dump_ready),
    .o_rf_addr    (dump_rf_addr),
    .i_rf_data    (regs[dump_rf_addr]),
    .o_dump_valid (o_dump_valid),
    .o_dump_addr  (o_dump_addr),
    .o_dump_data  (o_dump_data),
    .o_dump_last  (o_dump_last),
    .o_dump_busy  (o_dump_busy)
  );

endmodule

// File: tb/tb_regfile_mp_dump.sv
`timescale 1ns/1ps
module tb_regfile_mp_dump;
  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 5;
  localparam int N_READ  = 4;
  localparam int DEPTH   = 32;
`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      i_reset = 1'b0;
  logic                      i_we = 1'b0;
  logic [NB_ADDR-1:0]        i_wr_addr = '0;
  logic [NB_DATA-1:0]        i_wr_data = '0;
  logic [N_READ*NB_ADDR-1:0] i_rd_addr = '0;
  logic [N_READ*NB_DATA-1:0] o_rd_data;
  logic                      i_dump_start = 1'b0;
  logic                      o_dump_valid;
  logic                      i_dump_ready = 1'b0;
  logic [NB_ADDR-1:0]        o_dump_addr;
  logic [NB_DATA-1:0]        o_dump_data;
  logic                      o_dump_last;
  logic                      o_dump_busy;

  regfile_mp_dump #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .N_READ(N_READ)) dut (
    .clk(clk), .i_reset(i_reset), .i_we(i_we), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .i_dump_start(i_dump_start), .o_dump_valid(o_dump_valid),
    .i_dump_ready(i_dump_ready), .o_dump_addr(o_dump_addr),
    .o_dump_data(o_dump_data), .o_dump_last(o_dump_last),
    .o_dump_busy(o_dump_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain register array plus a dump pointer. A beat's
  // value is the register contents at the moment that beat gets loaded.
  typedef struct packed {
    logic [NB_ADDR-1:0] addr;
    logic [NB_DATA-1:0] data;
    logic               last;
  } beat_t;

  logic [NB_DATA-1:0] ref_regs [DEPTH];
  beat_t              exp_q [$];
  bit                 m_busy = 1'b0;
  int                 m_idx  = 0;

  always @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) ref_regs[i] = '0;
      m_busy = 1'b0;
      m_idx  = 0;
      exp_q.delete();
    end else begin
      if (!m_busy) begin
        if (i_dump_start) begin
          m_busy = 1'b1;
          m_idx  = 0;
          exp_q.push_back('{addr: '0, data: '0, last: 1'b0});
        end
      end else if (i_dump_ready) begin
        if (m_idx == DEPTH - 1) m_busy = 1'b0;
        else begin
          m_idx++;
          exp_q.push_back('{addr: NB_ADDR'(m_idx), data: ref_regs[m_idx],
                            last: (m_idx == DEPTH - 1)});
        end
      end
      if (i_we && i_wr_addr != '0) ref_regs[i_wr_addr] = i_wr_data;
    end
  end

  // Monitor: compares the presented beat (held or accepted) to the queue head.
  always @(negedge clk) begin
    if (!i_reset) begin
      beat_t act;
      checks++;
      if (o_dump_busy !== m_busy || o_dump_valid !== m_busy) begin
        errors++;
        $display("FAIL dump_state busy=%0b valid=%0b expected %0b", o_dump_busy, o_dump_valid, m_busy);
      end
      if (o_dump_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL dump_beat_unexpected addr=%0d data=%0h", o_dump_addr, o_dump_data);
        end else begin
          act = '{addr: o_dump_addr, data: o_dump_data, last: o_dump_last};
          if (act !== exp_q[0]) begin
            errors++;
            $display("FAIL dump_beat got addr=%0d data=%0h last=%0b expected addr=%0d data=%0h last=%0b",
                     act.addr, act.data, act.last, exp_q[0].addr, exp_q[0].data, exp_q[0].last);
          end
          if (i_dump_ready) void'(exp_q.pop_front());
        end
      end else begin
        checks++;
        if (o_dump_last !== 1'b0) begin
          errors++;
          $display("FAIL dump_last_idle got %0b expected 0", o_dump_last);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Check all read ports against the model, then advance one clock.
  task automatic tick();
    logic [NB_ADDR-1:0] ra;
    logic [NB_DATA-1:0] ex;
    @(negedge clk);
    for (int k = 0; k < N_READ; k++) begin
      ra = i_rd_addr[k*NB_ADDR +: NB_ADDR];
      ex = (ra == '0) ? '0 : ref_regs[ra];
      if (BYP && i_we && i_wr_addr == ra && ra != '0) ex = i_wr_data;
      checks++;
      if (o_rd_data[k*NB_DATA +: NB_DATA] !== ex) begin
        errors++;
        $display("FAIL rd_port%0d addr=%0d got %0h expected %0h", k, ra, o_rd_data[k*NB_DATA +: NB_DATA], ex);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [NB_ADDR-1:0] a, input logic [NB_DATA-1:0] d);
    i_we = 1'b1; i_wr_addr = a; i_wr_data = d;
    tick();
    i_we = 1'b0;
  endtask

  // mode 0: always ready; 1: pattern 1,0,0; 2: random
  task automatic drain(input int mode);
    int p;
    p = 0;
    while (m_busy && p < 400) begin
      case (mode)
        0: i_dump_ready = 1'b1;
        1: i_dump_ready = (p % 3 == 0);
        default: i_dump_ready = 1'($urandom_range(0, 1));
      endcase
      i_rd_addr = N_READ*NB_ADDR'($urandom);
      p++;
      tick();
    end
    checks++;
    if (m_busy) begin
      errors++;
      $display("FAIL dump_timeout got busy=1 expected busy=0");
    end
    i_dump_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 i_reset = 1'b1;
    #2;
    chk("reset_rd_data", 128'(o_rd_data), 128'h0);
    chk("reset_dump_outs", {o_dump_valid, o_dump_last, o_dump_busy, o_dump_addr, o_dump_data}, 128'h0);
    @(posedge clk); #1;
    i_reset = 1'b0;
    tick();

    // Write r5, then reset asynchronously mid-cycle.
    wr(5'd5, 32'hDEADBEEF);
    i_rd_addr = {5'd0, 5'd0, 5'd0, 5'd5};
    #1 chk("r5_written", 128'(o_rd_data[NB_DATA-1:0]), 128'hDEADBEEF);
    i_reset = 1'b1;
    #1 chk("r5_after_async_reset", 128'(o_rd_data[NB_DATA-1:0]), 128'h0);
    chk("valid_after_reset", 128'(o_dump_valid), 128'h0);
    #1 i_reset = 1'b0;
    tick();

    // Zero register.
    i_rd_addr = '0;
    wr(5'd0, 32'hFFFFFFFF);
    #2 chk("zero_reg_all_ports", 128'(o_rd_data), 128'h0);
    tick();

    // Multi-port read.
    wr(5'd1, 32'h11); wr(5'd2, 32'h22); wr(5'd3, 32'h33); wr(5'd4, 32'h44);
    i_rd_addr = {5'd1, 5'd2, 5'd3, 5'd4};
    #2 chk("multiport", 128'(o_rd_data), {32'h11, 32'h22, 32'h33, 32'h44});
    tick();

    // Same-cycle write/read of r7.
    i_rd_addr = {5'd0, 5'd0, 5'd0, 5'd7};
    i_we = 1'b1; i_wr_addr = 5'd7; i_wr_data = 32'hA5;
    #2 chk("bypass_same_cycle", 128'(o_rd_data[NB_DATA-1:0]), BYP ? 128'hA5 : 128'h0);
    tick();
    i_we = 1'b0;
    #2 chk("write_next_cycle", 128'(o_rd_data[NB_DATA-1:0]), 128'hA5);
    tick();

    // Preload rN = N*0x10, dump with ready pattern 1,0,0.
    for (int a = 1; a < DEPTH; a++) wr(NB_ADDR'(a), NB_DATA'(a * 16));
    i_dump_start = 1'b1; tick(); i_dump_start = 1'b0;
    drain(1);
    chk("queue_empty_dump1", 128'(exp_q.size()), 128'h0);

    // Collision: stall on beat 9, core writes r9 meanwhile, start is ignored.
    i_dump_start = 1'b1; tick(); i_dump_start = 1'b0;
    i_dump_ready = 1'b1;
    n = 0;
    while (!(m_busy && m_idx == 9) && n < 100) begin n++; tick(); end
    chk("reach_beat9", 128'(m_idx), 128'd9);
    i_dump_ready = 1'b0;
    i_we = 1'b1; i_wr_addr = 5'd9; i_wr_data = 32'h99; i_dump_start = 1'b1;
    #2 chk("beat9_addr", 128'(o_dump_addr), 128'd9);
    tick();
    i_we = 1'b0; i_dump_start = 1'b0;
    tick(); tick();
    chk("beat9_snapshot", 128'(o_dump_data), 128'h90);
    drain(0);
    i_dump_start = 1'b1; tick(); i_dump_start = 1'b0;
    drain(2);
    chk("queue_empty_dump3", 128'(exp_q.size()), 128'h0);

    // Randomised traffic with overlapping dumps.
    for (int c = 0; c < 1500; c++) begin
      i_we         = 1'($urandom_range(0, 1));
      i_wr_addr    = NB_ADDR'($urandom);
      i_wr_data    = $urandom;
      i_rd_addr    = N_READ*NB_ADDR'($urandom);
      if ($urandom_range(0, 3) == 0) i_rd_addr[NB_ADDR-1:0] = i_wr_addr;
      i_dump_start = ($urandom_range(0, 19) == 0);
      i_dump_ready = 1'($urandom_range(0, 1));
      tick();
    end
    i_we = 1'b0; i_dump_start = 1'b0;
    drain(0);

    // Reset in the middle of a dump.
    i_dump_start = 1'b1; tick(); i_dump_start = 1'b0;
    for (int c = 0; c < 10; c++) begin i_dump_ready = 1'($urandom_range(0, 1)); tick(); end
    i_reset = 1'b1;
    #1 chk("abort_outs", {o_dump_valid, o_dump_last, o_dump_busy, o_dump_addr, o_dump_data}, 128'h0);
    #1 i_reset = 1'b0;
    i_dump_ready = 1'b0;
    tick(); tick();
    chk("queue_empty_end", 128'(exp_q.size()), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
